// File: rtl/bcd_down_timer_pkg.sv
// Shared constants, FSM encoding and digit-modulus helper for the BCD down timer.
package bcd_down_timer_pkg;

    localparam int BCD_W     = 4;
    localparam int MOD_UNITS = 10;
    localparam int MOD_TENS  = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_e;

    // Odd-index digits are the tens of seconds/minutes when mm:ss mode is on.
    function automatic int digit_mod(input int idx, input bit minsec);
        return (minsec && idx[0]) ? MOD_TENS : MOD_UNITS;
    endfunction

endpackage

// File: rtl/bcd_down_timer_digit.sv
// One BCD digit register: sanitising load, borrow-chained decrement with wrap to MOD-1.
module bcd_digit_down
    import bcd_down_timer_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic             clock_i,
    input  logic             clearn_i,
    input  logic             load_i,
    input  logic [BCD_W-1:0] data_i,
    input  logic             dec_i,
    input  logic             borrow_i,
    output logic             borrow_o,
    output logic             is_zero_o,
    output logic [BCD_W-1:0] san_o,
    output logic [BCD_W-1:0] digit_o
);

    localparam logic [BCD_W-1:0] MAX_DIGIT = BCD_W'(MOD - 1);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    assign san_o     = (data_i > MAX_DIGIT) ? '0 : data_i;
    assign is_zero_o = (digit_q == '0);
    assign borrow_o  = borrow_i & is_zero_o;
    assign digit_o   = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = san_o;
        end else if (dec_i && borrow_i) begin
            digit_d = is_zero_o ? MAX_DIGIT : digit_q - BCD_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (!clearn_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down timer: run/pause/expire FSM, reload shadow, one-cycle tc on expiry.
module bcd_down_timer
    import bcd_down_timer_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter bit MINSEC      = 1'b1,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                        clock_i,
    input  logic                        clearn_i,
    input  logic [BCD_W*NUM_DIGITS-1:0] data_i,
    input  logic                        loadn_i,
    input  logic                        start_i,
    input  logic                        stop_i,
    input  logic                        tick_i,
    output logic [BCD_W*NUM_DIGITS-1:0] digits_o,
    output logic                        zero_o,
    output logic                        tc_o,
    output logic                        running_o
);

    localparam int VW = BCD_W * NUM_DIGITS;

    state_e          state_q, state_d;
    logic            tc_q, tc_d;
    logic [VW-1:0]   shadow_q, shadow_d;
    logic [VW-1:0]   san;
    logic [VW-1:0]   ld_dat;
    logic            ld_en;
    logic            dec_en;
    logic            is_one;
    logic [NUM_DIGITS:0]   borrow;
    logic [NUM_DIGITS-1:0] is_zero;

    // Outside an external load the only load source is the reload shadow.
    assign ld_dat    = loadn_i ? shadow_q : data_i;
    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_digit
        bcd_digit_down #(
            .MOD(digit_mod(g, MINSEC))
        ) u_digit (
            .clock_i  (clock_i),
            .clearn_i (clearn_i),
            .load_i   (ld_en),
            .data_i   (ld_dat[BCD_W*g +: BCD_W]),
            .dec_i    (dec_en),
            .borrow_i (borrow[g]),
            .borrow_o (borrow[g+1]),
            .is_zero_o(is_zero[g]),
            .san_o    (san[BCD_W*g +: BCD_W]),
            .digit_o  (digits_o[BCD_W*g +: BCD_W])
        );
    end

    // A borrow escaping the top digit means every digit is zero.
    assign zero_o    = borrow[NUM_DIGITS];
    assign is_one    = (digits_o[BCD_W-1:0] == BCD_W'(1)) &&
                       (&(is_zero | (NUM_DIGITS)'(1)));
    assign tc_o      = tc_q;
    assign running_o = (state_q == ST_RUN);

    always_comb begin
        state_d  = state_q;
        tc_d     = 1'b0;
        shadow_d = shadow_q;
        ld_en    = 1'b0;
        dec_en   = 1'b0;
        if (!loadn_i) begin
            ld_en    = 1'b1;
            shadow_d = san;
            state_d  = ST_IDLE;
        end else if (stop_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !zero_o) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick_i) begin
                        if (zero_o) begin
                            if (AUTO_RELOAD && (shadow_q != '0)) begin
                                ld_en = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            dec_en = 1'b1;
                            if (is_one) begin
                                tc_d = 1'b1;
                                if (!AUTO_RELOAD) begin
                                    state_d = ST_EXPIRED;
                                end
                            end
                        end
                    end
                end
                ST_EXPIRED: begin
                    state_d = ST_EXPIRED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (!clearn_i) begin
            state_q  <= ST_IDLE;
            tc_q     <= 1'b0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            tc_q     <= tc_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer: vector table plus hand-written multi-cycle sequences.
module tb_bcd_down_timer;

    logic        clk;
    logic        clearn, loadn, start, stop, tick;
    logic [15:0] data;
    logic [15:0] dig, dig_ar;
    logic        zero, tc, run;
    logic        zero_ar, tc_ar, run_ar;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bcd_down_timer #(.NUM_DIGITS(4), .MINSEC(1'b1), .AUTO_RELOAD(1'b0)) dut (
        .clock_i(clk), .clearn_i(clearn), .data_i(data), .loadn_i(loadn),
        .start_i(start), .stop_i(stop), .tick_i(tick),
        .digits_o(dig), .zero_o(zero), .tc_o(tc), .running_o(run)
    );

    bcd_down_timer #(.NUM_DIGITS(4), .MINSEC(1'b1), .AUTO_RELOAD(1'b1)) dut_ar (
        .clock_i(clk), .clearn_i(clearn), .data_i(data), .loadn_i(loadn),
        .start_i(start), .stop_i(stop), .tick_i(tick),
        .digits_o(dig_ar), .zero_o(zero_ar), .tc_o(tc_ar), .running_o(run_ar)
    );

    typedef struct {
        string       name;
        logic        clearn, loadn, start, stop, tick;
        logic [15:0] data;
        logic [15:0] exp_dig;
        logic        exp_zero, exp_tc, exp_run;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input string n, input logic cl, input logic ld,
                               input logic st, input logic sp, input logic tk,
                               input logic [15:0] d, input logic [15:0] ed,
                               input logic ez, input logic et, input logic er);
        vec_t r;
        r.name = n; r.clearn = cl; r.loadn = ld; r.start = st; r.stop = sp; r.tick = tk;
        r.data = d; r.exp_dig = ed; r.exp_zero = ez; r.exp_tc = et; r.exp_run = er;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic cl, input logic ld, input logic st,
                         input logic sp, input logic tk, input logic [15:0] d);
        clearn = cl; loadn = ld; start = st; stop = sp; tick = tk; data = d;
        @(posedge clk);
        #1;
        clearn = 1'b1; loadn = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0;
    endtask

    task automatic chk_main(input string nm, input logic [15:0] ed,
                            input logic ez, input logic et, input logic er);
        chk({nm, ".digits"}, dig, ed);
        chk({nm, ".zero"}, {15'd0, zero}, {15'd0, ez});
        chk({nm, ".tc"}, {15'd0, tc}, {15'd0, et});
        chk({nm, ".running"}, {15'd0, run}, {15'd0, er});
    endtask

    task automatic chk_ar(input string nm, input logic [15:0] ed,
                          input logic et, input logic er);
        chk({nm, ".digits"}, dig_ar, ed);
        chk({nm, ".tc"}, {15'd0, tc_ar}, {15'd0, et});
        chk({nm, ".running"}, {15'd0, run_ar}, {15'd0, er});
    endtask

    initial begin
        clearn = 1'b1; loadn = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0; data = '0;

        //               name         cl ld st sp tk  data      digits   z  tc run
        vecs.push_back(v("reset",      0, 1, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0));
        vecs.push_back(v("ld0002",     1, 0, 0, 0, 0, 16'h0002, 16'h0002, 0, 0, 0));
        vecs.push_back(v("start2",     1, 1, 1, 0, 0, 16'h0000, 16'h0002, 0, 0, 1));
        vecs.push_back(v("tick2a",     1, 1, 0, 0, 1, 16'h0000, 16'h0001, 0, 0, 1));
        vecs.push_back(v("expire",     1, 1, 0, 0, 1, 16'h0000, 16'h0000, 1, 1, 0));
        vecs.push_back(v("tc_drop",    1, 1, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v("exp_tick", 1, 1, 0, 0, 1, 16'h0000, 16'h0000, 1, 0, 0));
        vecs.push_back(v("exp_start",  1, 1, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0));
        vecs.push_back(v("exp_stop",   1, 1, 0, 1, 0, 16'h0000, 16'h0000, 1, 0, 0));
        vecs.push_back(v("ld0010",     1, 0, 0, 0, 0, 16'h0010, 16'h0010, 0, 0, 0));
        vecs.push_back(v("start10",    1, 1, 1, 0, 0, 16'h0000, 16'h0010, 0, 0, 1));
        vecs.push_back(v("t10a",       1, 1, 0, 0, 1, 16'h0000, 16'h0009, 0, 0, 1));
        vecs.push_back(v("t10b",       1, 1, 0, 0, 1, 16'h0000, 16'h0008, 0, 0, 1));
        vecs.push_back(v("t10c",       1, 1, 0, 0, 1, 16'h0000, 16'h0007, 0, 0, 1));
        vecs.push_back(v("pause",      1, 1, 0, 1, 0, 16'h0000, 16'h0007, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(v("idle_tick", 1, 1, 0, 0, 1, 16'h0000, 16'h0007, 0, 0, 0));
        vecs.push_back(v("resume",     1, 1, 1, 0, 0, 16'h0000, 16'h0007, 0, 0, 1));
        vecs.push_back(v("t10d",       1, 1, 0, 0, 1, 16'h0000, 16'h0006, 0, 0, 1));
        vecs.push_back(v("stop_tick",  1, 1, 0, 1, 1, 16'h0000, 16'h0006, 0, 0, 0));
        vecs.push_back(v("restart",    1, 1, 1, 0, 0, 16'h0000, 16'h0006, 0, 0, 1));
        vecs.push_back(v("t10e",       1, 1, 0, 0, 1, 16'h0000, 16'h0005, 0, 0, 1));
        vecs.push_back(v("rst_run",    0, 1, 0, 0, 1, 16'h0000, 16'h0000, 1, 0, 0));
        vecs.push_back(v("ld0001",     1, 0, 0, 0, 0, 16'h0001, 16'h0001, 0, 0, 0));
        vecs.push_back(v("start1",     1, 1, 1, 0, 0, 16'h0000, 16'h0001, 0, 0, 1));
        vecs.push_back(v("rst_exp",    0, 1, 0, 0, 1, 16'h0000, 16'h0000, 1, 0, 0));
        vecs.push_back(v("ld_start",   1, 0, 1, 0, 0, 16'h0A79, 16'h0009, 0, 0, 0));
        vecs.push_back(v("no_resamp",  1, 1, 0, 0, 1, 16'h0000, 16'h0009, 0, 0, 0));
        vecs.push_back(v("clear",      0, 1, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0));
        vecs.push_back(v("start0",     1, 1, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0));
        vecs.push_back(v("tick0",      1, 1, 0, 0, 1, 16'h0000, 16'h0000, 1, 0, 0));
        vecs.push_back(v("ld5959",     1, 0, 0, 0, 0, 16'h5959, 16'h5959, 0, 0, 0));
        vecs.push_back(v("start59",    1, 1, 1, 0, 0, 16'h0000, 16'h5959, 0, 0, 1));
        vecs.push_back(v("t59",        1, 1, 0, 0, 1, 16'h0000, 16'h5958, 0, 0, 1));
        vecs.push_back(v("ld_vs_tick", 1, 0, 0, 0, 1, 16'h0003, 16'h0003, 0, 0, 0));
        vecs.push_back(v("ld9999",     1, 0, 0, 0, 0, 16'h9999, 16'h0909, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clearn, vecs[i].loadn, vecs[i].start, vecs[i].stop,
                  vecs[i].tick, vecs[i].data);
            chk_main(vecs[i].name, vecs[i].exp_dig, vecs[i].exp_zero,
                     vecs[i].exp_tc, vecs[i].exp_run);
        end

        // mm:ss borrow: 01:30 minus 31 seconds is 00:59
        drive(1, 0, 0, 0, 0, 16'h0130);
        drive(1, 1, 1, 0, 0, 16'h0000);
        drive(1, 1, 0, 0, 1, 16'h0000);
        chk_main("mmss_1", 16'h0129, 0, 0, 1);
        for (int i = 0; i < 29; i++) drive(1, 1, 0, 0, 1, 16'h0000);
        chk_main("mmss_30", 16'h0100, 0, 0, 1);
        drive(1, 1, 0, 0, 1, 16'h0000);
        chk_main("mmss_31", 16'h0059, 0, 0, 1);

        // Borrow rippling through three zero digits
        drive(1, 0, 0, 0, 0, 16'h1000);
        drive(1, 1, 1, 0, 0, 16'h0000);
        drive(1, 1, 0, 0, 1, 16'h0000);
        chk_main("ripple", 16'h0959, 0, 0, 1);

        // Auto-reload instance
        drive(0, 1, 0, 0, 0, 16'h0000);
        chk_ar("ar_reset", 16'h0000, 0, 0);
        drive(1, 0, 0, 0, 0, 16'h0003);
        drive(1, 1, 1, 0, 0, 16'h0000);
        chk_ar("ar_start", 16'h0003, 0, 1);
        drive(1, 1, 0, 0, 1, 16'h0000);
        drive(1, 1, 0, 0, 1, 16'h0000);
        chk_ar("ar_t2", 16'h0001, 0, 1);
        drive(1, 1, 0, 0, 1, 16'h0000);
        chk_ar("ar_expire", 16'h0000, 1, 1);
        chk("ar_zero", {15'd0, zero_ar}, 16'h0001);
        drive(1, 1, 0, 0, 0, 16'h0000);
        chk_ar("ar_tc_drop", 16'h0000, 0, 1);
        drive(1, 1, 0, 0, 1, 16'h0000);
        chk_ar("ar_reload", 16'h0003, 0, 1);
        drive(1, 1, 0, 0, 1, 16'h0000);
        chk_ar("ar_after", 16'h0002, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
